rx_frame_check: RTL and testbench

RX_FRAME_CHECK -- requirements
Module: rx_frame_check

---
 rtl/rx_frame_check_pkg.sv | 26 ++
 rtl/rx_frame_check_if.sv | 31 +++
 rtl/rx_frame_check_parity.sv | 28 ++
 rtl/rx_frame_check.sv | 133 +++++++++++++
 tb/tb_rx_frame_check.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_frame_check_pkg.sv
// rx_frame_pkg
// Shared definitions for the UART receive frame checker: the parity_type
// encodings, the frame FSM states and the bit counter width.
// No ports (package).

package rx_frame_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Wide enough to count up to the largest legal DATA_WIDTH (9).
  localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/rx_frame_check_if.sv
// rx_frame_check_if
// Bundles the sampled bit stream coming from the oversampling front end with
// the per-frame result going to the consumer.
//   frame_start, sampled_data, sampled_data_valid : bit stream into the checker
//   rx_data, data_valid, parity_error, stop_error : frame result out of it
// master : the side that drives the bit stream and receives the result
// slave  : the frame checker itself

interface rx_frame_check_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  frame_start;
  logic                  sampled_data;
  logic                  sampled_data_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;

  modport master (
    output frame_start, sampled_data, sampled_data_valid,
    input  rx_data, data_valid, parity_error, stop_error
  );

  modport slave (
    input  frame_start, sampled_data, sampled_data_valid,
    output rx_data, data_valid, parity_error, stop_error
  );

endinterface

// File: rtl/rx_frame_check_parity.sv
// rx_parity_gen
// Combinational expected-parity bit for an assembled data word.
//   data     : assembled data word
//   mode     : parity mode (even, odd, mark, space)
//   expected : parity bit the line should carry

module rx_parity_gen
  import rx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  parity_mode_e          mode,
  output logic                  expected
);

  always_comb begin
    expected = 1'b0;
    case (mode)
      PAR_EVEN:  expected = ^data;
      PAR_ODD:   expected = ~^data;
      PAR_MARK:  expected = 1'b1;
      PAR_SPACE: expected = 1'b0;
      default:   expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/rx_frame_check.sv
// rx_frame_check
// Assembles one UART frame from majority-voted samples, checks its parity and
// stop bits, and keeps saturating totals of parity and stop errors.
//   clk_based_on_prescale : oversampled bit-rate clock, rising edge only
//   asy_reset             : synchronous active-high reset
//   parity_enable         : frame carries a parity bit (captured at frame_start)
//   parity_type           : 00 even, 01 odd, 10 mark, 11 space (captured at frame_start)
//   err_clear             : zeroes both error counters
//   busy                  : high whenever the FSM is not IDLE
//   parity_err_count      : saturating count of frames with a parity error
//   stop_err_count        : saturating count of frames with a stop error
//   bus                   : bit stream in, frame result out (slave modport)

module rx_frame_check
  import rx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk_based_on_prescale,
  input  logic                 asy_reset,
  input  logic                 parity_enable,
  input  logic [1:0]           parity_type,
  input  logic                 err_clear,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] parity_err_count,
  output logic [CNT_WIDTH-1:0] stop_err_count,
  rx_frame_check_if.slave      bus
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  state_e                 state;
  state_e                 state_next;
  logic [BIT_CNT_W-1:0]   bit_count;
  logic                   par_en_q;
  parity_mode_e           par_type_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   par_err_q;
  logic                   stop_err_q;
  logic                   par_expected;

  rx_parity_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data     (data_q),
    .mode     (par_type_q),
    .expected (par_expected)
  );

  assign bus.rx_data      = data_q;
  assign bus.parity_error = par_err_q;
  assign bus.stop_error   = stop_err_q;

  // A frame_start anywhere wins over whatever the current state would do,
  // which both aborts a frame in flight and drops a coincident sample.
  always_comb begin
    state_next     = state;
    busy           = (state != IDLE);
    bus.data_valid = (state == DONE);
    case (state)
      IDLE: state_next = IDLE;
      DATA:
        if (bus.sampled_data_valid && bit_count == LAST_DATA)
          state_next = par_en_q ? PARITY : STOP;
      PARITY:
        if (bus.sampled_data_valid)
          state_next = STOP;
      STOP:
        if (bus.sampled_data_valid && bit_count == LAST_STOP)
          state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.frame_start)
      state_next = DATA;
  end

  // Frame datapath. Configuration is latched at frame_start so a mid-frame
  // change on the config pins cannot corrupt the frame being received.
  // rx_data is only touched while shifting, so it holds after DONE.
  always_ff @(posedge clk_based_on_prescale) begin
    if (asy_reset) begin
      state      <= IDLE;
      bit_count  <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= PAR_EVEN;
      data_q     <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (bus.frame_start) begin
        bit_count  <= '0;
        par_en_q   <= parity_enable;
        par_type_q <= parity_mode_e'(parity_type);
        par_err_q  <= 1'b0;
        stop_err_q <= 1'b0;
      end else if (bus.sampled_data_valid) begin
        case (state)
          DATA: begin
            data_q    <= {bus.sampled_data, data_q[DATA_WIDTH-1:1]};
            bit_count <= (bit_count == LAST_DATA) ? '0 : bit_count + 1'b1;
          end
          PARITY: par_err_q <= (bus.sampled_data != par_expected);
          STOP: begin
            if (!bus.sampled_data)
              stop_err_q <= 1'b1;
            bit_count <= bit_count + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Error totals bump once per completed frame and stick at all-ones;
  // a clear in the same cycle as a bump wins.
  always_ff @(posedge clk_based_on_prescale) begin
    if (asy_reset || err_clear) begin
      parity_err_count <= '0;
      stop_err_count   <= '0;
    end else if (state == DONE) begin
      if (par_err_q && parity_err_count != '1)
        parity_err_count <= parity_err_count + 1'b1;
      if (stop_err_q && stop_err_count != '1)
        stop_err_count <= stop_err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_frame_check.sv
// tb_rx_frame_check
// Self-checking bench for rx_frame_check. Instance A: 8 data bits, 1 stop bit.
// Instance B: 7 data bits, 2 stop bits. Expected frame results are queued as
// frames are driven and popped by a monitor whenever data_valid is seen.

module tb_rx_frame_check;
  import rx_frame_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic [1:0] pt;
    logic       pbit;
    logic       sbit;
    int         gap;
    logic       exp_perr;
    logic       exp_serr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       par_en_a, par_en_b, clr_a, clr_b;
  logic [1:0] ptype_a, ptype_b;
  logic       busy_a, busy_b;
  logic [7:0] pcnt_a, scnt_a, pcnt_b, scnt_b;

  rx_frame_check_if #(.DATA_WIDTH(8)) bus_a ();
  rx_frame_check_if #(.DATA_WIDTH(7)) bus_b ();

  rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) dut_a (
    .clk_based_on_prescale (clk),
    .asy_reset             (rst_a),
    .parity_enable         (par_en_a),
    .parity_type           (ptype_a),
    .err_clear             (clr_a),
    .busy                  (busy_a),
    .parity_err_count      (pcnt_a),
    .stop_err_count        (scnt_a),
    .bus                   (bus_a.slave)
  );

  rx_frame_check #(.DATA_WIDTH(7), .STOP_BITS(2), .CNT_WIDTH(8)) dut_b (
    .clk_based_on_prescale (clk),
    .asy_reset             (rst_b),
    .parity_enable         (par_en_b),
    .parity_type           (ptype_b),
    .err_clear             (clr_b),
    .busy                  (busy_b),
    .parity_err_count      (pcnt_b),
    .stop_err_count        (scnt_b),
    .bus                   (bus_b.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   dv_count_a = 0;
  int   dv_count_b = 0;
  logic prev_dv_a = 1'b0;
  logic prev_dv_b = 1'b0;
  int   m_pcnt_a = 0, m_scnt_a = 0, m_scnt_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vecs[8];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every data_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus_a.data_valid) begin
      dv_count_a = dv_count_a + 1;
      check_output("dv_single_cycle_a", {31'd0, prev_dv_a}, 32'd0);
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_dv_a: got data_valid=1, expected no frame");
      end else begin
        e = q_a.pop_front();
        check_output("rx_data_a", {24'd0, bus_a.rx_data}, {24'd0, e.data});
        check_output("parity_error_a", {31'd0, bus_a.parity_error}, {31'd0, e.perr});
        check_output("stop_error_a", {31'd0, bus_a.stop_error}, {31'd0, e.serr});
      end
    end
    prev_dv_a = bus_a.data_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_b.data_valid) begin
      dv_count_b = dv_count_b + 1;
      check_output("dv_single_cycle_b", {31'd0, prev_dv_b}, 32'd0);
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_dv_b: got data_valid=1, expected no frame");
      end else begin
        e = q_b.pop_front();
        check_output("rx_data_b", {25'd0, bus_b.rx_data}, {24'd0, e.data});
        check_output("parity_error_b", {31'd0, bus_b.parity_error}, {31'd0, e.perr});
        check_output("stop_error_b", {31'd0, bus_b.stop_error}, {31'd0, e.serr});
      end
    end
    prev_dv_b = bus_b.data_valid;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit_a(input logic b, input int gap);
    repeat (gap) cycle();
    bus_a.sampled_data       = b;
    bus_a.sampled_data_valid = 1'b1;
    cycle();
    bus_a.sampled_data_valid = 1'b0;
  endtask

  task automatic send_bit_b(input logic b, input int gap);
    repeat (gap) cycle();
    bus_b.sampled_data       = b;
    bus_b.sampled_data_valid = 1'b1;
    cycle();
    bus_b.sampled_data_valid = 1'b0;
  endtask

  // Config pins are flipped right after frame_start to show they are latched.
  task automatic apply_frame_a(input logic [7:0] d, input logic pe, input logic [1:0] pt,
                               input logic pb, input logic sb, input int gap);
    par_en_a = pe;
    ptype_a  = pt;
    bus_a.frame_start = 1'b1;
    cycle();
    bus_a.frame_start = 1'b0;
    par_en_a = ~pe;
    ptype_a  = ~pt;
    for (int i = 0; i < 8; i++) send_bit_a(d[i], gap);
    if (pe) send_bit_a(pb, gap);
    send_bit_a(sb, gap);
  endtask

  task automatic apply_frame_b(input logic [6:0] d, input logic s1, input logic s2, input int gap);
    par_en_b = 1'b0;
    bus_b.frame_start = 1'b1;
    cycle();
    bus_b.frame_start = 1'b0;
    for (int i = 0; i < 7; i++) send_bit_b(d[i], gap);
    send_bit_b(s1, gap);
    send_bit_b(s2, gap);
  endtask

  task automatic wait_dv_a(input int target);
    int n = 0;
    while (dv_count_a < target && n < 200) begin cycle(); n++; end
    check_output("dv_arrived_a", dv_count_a, target);
  endtask

  task automatic wait_dv_b(input int target);
    int n = 0;
    while (dv_count_b < target && n < 200) begin cycle(); n++; end
    check_output("dv_arrived_b", dv_count_b, target);
  endtask

  initial begin
    int dv_before;

    vecs[0] = '{8'hA5, 1'b1, 2'b00, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 2'b01, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 2'b00, 1'b0, 1'b1, 2, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 2'b10, 1'b1, 1'b1, 0, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 2'b11, 1'b1, 1'b1, 1, 1'b1, 1'b0};
    vecs[5] = '{8'h12, 1'b1, 2'b00, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[6] = '{8'h07, 1'b1, 2'b01, 1'b0, 1'b1, 3, 1'b0, 1'b0};
    vecs[7] = '{8'hC3, 1'b0, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b1};

    rst_a = 1'b1; rst_b = 1'b1;
    par_en_a = 1'b0; par_en_b = 1'b0; ptype_a = 2'b00; ptype_b = 2'b00;
    clr_a = 1'b0; clr_b = 1'b0;
    bus_a.frame_start = 1'b0; bus_a.sampled_data = 1'b0; bus_a.sampled_data_valid = 1'b0;
    bus_b.frame_start = 1'b0; bus_b.sampled_data = 1'b0; bus_b.sampled_data_valid = 1'b0;
    repeat (3) cycle();
    rst_a = 1'b0; rst_b = 1'b0;

    $display("[TB] reset state");
    check_output("reset_busy", {31'd0, busy_a}, 32'd0);
    check_output("reset_dv", {31'd0, bus_a.data_valid}, 32'd0);
    check_output("reset_rx_data", {24'd0, bus_a.rx_data}, 32'd0);
    check_output("reset_perr", {31'd0, bus_a.parity_error}, 32'd0);
    check_output("reset_serr", {31'd0, bus_a.stop_error}, 32'd0);
    check_output("reset_pcnt", {24'd0, pcnt_a}, 32'd0);
    check_output("reset_scnt", {24'd0, scnt_a}, 32'd0);

    $display("[TB] table-driven frames");
    for (int i = 0; i < 8; i++) begin
      q_a.push_back('{vecs[i].data, vecs[i].exp_perr, vecs[i].exp_serr});
      if (vecs[i].exp_perr) m_pcnt_a++;
      if (vecs[i].exp_serr) m_scnt_a++;
      apply_frame_a(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].pbit, vecs[i].sbit, vecs[i].gap);
      wait_dv_a(dv_count_a + 1);
      cycle();
      check_output("pcnt_a", {24'd0, pcnt_a}, m_pcnt_a);
      check_output("scnt_a", {24'd0, scnt_a}, m_scnt_a);
      check_output("idle_busy_a", {31'd0, busy_a}, 32'd0);
    end

    $display("[TB] abort after 4 data bits");
    dv_before = dv_count_a;
    par_en_a = 1'b0;
    bus_a.frame_start = 1'b1;
    cycle();
    bus_a.frame_start = 1'b0;
    send_bit_a(1'b0, 0); send_bit_a(1'b1, 0); send_bit_a(1'b1, 0); send_bit_a(1'b0, 0);
    q_a.push_back('{8'h3C, 1'b0, 1'b0});
    apply_frame_a(8'h3C, 1'b0, 2'b00, 1'b0, 1'b1, 0);
    wait_dv_a(dv_before + 1);
    repeat (10) cycle();
    check_output("abort_single_dv", dv_count_a, dv_before + 1);

    $display("[TB] frame_start coincident with a valid bit");
    par_en_a = 1'b0;
    bus_a.frame_start = 1'b1;
    bus_a.sampled_data = 1'b1;
    bus_a.sampled_data_valid = 1'b1;
    cycle();
    bus_a.frame_start = 1'b0;
    bus_a.sampled_data_valid = 1'b0;
    q_a.push_back('{8'h5A, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) send_bit_a(((8'h5A >> i) & 8'h01) != 0, 0);
    send_bit_a(1'b1, 0);
    wait_dv_a(dv_count_a + 1);

    $display("[TB] err_clear coincident with an increment");
    q_a.push_back('{8'h81, 1'b1, 1'b0});
    apply_frame_a(8'h81, 1'b1, 2'b11, 1'b1, 1'b1, 0);
    clr_a = 1'b1;
    cycle();
    clr_a = 1'b0;
    m_pcnt_a = 0; m_scnt_a = 0;
    wait_dv_a(dv_count_a);
    repeat (2) cycle();
    check_output("clear_pcnt_a", {24'd0, pcnt_a}, m_pcnt_a);
    check_output("clear_scnt_a", {24'd0, scnt_a}, m_scnt_a);

    q_a.push_back('{8'h00, 1'b1, 1'b0});
    apply_frame_a(8'h00, 1'b1, 2'b01, 1'b0, 1'b1, 0);
    wait_dv_a(dv_count_a + 1);
    cycle();
    check_output("pcnt_after_clear_a", {24'd0, pcnt_a}, 32'd1);

    $display("[TB] reset in PARITY");
    dv_before = dv_count_a;
    par_en_a = 1'b1;
    ptype_a = 2'b00;
    bus_a.frame_start = 1'b1;
    cycle();
    bus_a.frame_start = 1'b0;
    for (int i = 0; i < 8; i++) send_bit_a(i[0], 0);
    check_output("busy_in_parity", {31'd0, busy_a}, 32'd1);
    rst_a = 1'b1;
    cycle();
    rst_a = 1'b0;
    check_output("busy_after_reset", {31'd0, busy_a}, 32'd0);
    send_bit_a(1'b1, 0);
    send_bit_a(1'b1, 0);
    repeat (5) cycle();
    check_output("no_dv_after_reset", dv_count_a, dv_before);
    check_output("pcnt_after_reset", {24'd0, pcnt_a}, 32'd0);
    check_output("scnt_after_reset", {24'd0, scnt_a}, 32'd0);
    check_output("rx_data_after_reset", {24'd0, bus_a.rx_data}, 32'd0);

    $display("[TB] 7-bit frame with 16-cycle gaps");
    q_b.push_back('{8'h55, 1'b0, 1'b0});
    apply_frame_b(7'h55, 1'b1, 1'b1, 16);
    wait_dv_b(dv_count_b + 1);

    $display("[TB] stop error saturation");
    for (int i = 0; i < 256; i++) begin
      q_b.push_back('{8'h2A, 1'b0, 1'b1});
      if (m_scnt_b < 255) m_scnt_b++;
      apply_frame_b(7'h2A, (i == 0) ? 1'b0 : 1'b1, (i == 0) ? 1'b1 : 1'b0, 0);
      wait_dv_b(dv_count_b + 1);
      cycle();
      if (i == 0 || i >= 254)
        check_output("scnt_b", {24'd0, scnt_b}, m_scnt_b);
    end
    check_output("pcnt_b", {24'd0, pcnt_b}, 32'd0);

    check_output("queue_a_empty", q_a.size(), 32'd0);
    check_output("queue_b_empty", q_b.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
